// File: rtl/score_display_pkg.sv
// Shared constants for the score display: segment patterns (active-low {g,f,e,d,c,b,a})
// and active-low one-hot anode enables.
package score_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_SLOT0  = 4'b1110;
    localparam logic [3:0] AN_SLOT1  = 4'b1101;
    localparam logic [3:0] AN_SLOT2  = 4'b1011;
    localparam logic [3:0] AN_SLOT3  = 4'b0111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
        case (slot)
            2'd0:    return AN_SLOT0;
            2'd1:    return AN_SLOT1;
            2'd2:    return AN_SLOT2;
            default: return AN_SLOT3;
        endcase
    endfunction

endpackage

// File: rtl/score_display_seg_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
module seg_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display with per-frame snapshot and score-change flash on dp.
// Optional leading-zero blanking: define SCORE_LEADING_ZERO_BLANK_EN.
module score_display
    import score_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] score_dig1,
    input  logic [3:0] score_dig2,
    input  logic [3:0] score_dig3,
    input  logic [3:0] score_dig4,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    logic [PW-1:0]   presc;
    logic            tick;
    logic [1:0]      idx;
    logic [1:0]      idx_nxt;
    logic            frame_start;
    logic [3:0][3:0] live;
    logic [3:0][3:0] snap;
    logic            changed;
    logic [FW-1:0]   flash;
    logic [FW-1:0]   flash_nxt;
    logic [3:0]      dec_in;
    logic [6:0]      dec_out;
    logic            blank;

    assign tick        = (presc == PW'(REFRESH_DIV - 1));
    assign idx_nxt     = idx + 2'd1;
    assign frame_start = tick && (idx_nxt == 2'd0);
    assign live        = {score_dig4, score_dig3, score_dig2, score_dig1};
    // The snapshot still holds the previous frame's score at the load edge.
    assign changed     = (live != snap);

    always_comb begin
        flash_nxt = flash;
        if (changed)
            flash_nxt = FW'(FLASH_FRAMES);
        else if (flash != '0)
            flash_nxt = flash - FW'(1);
    end

    // Slot 0 is decoded from the live inputs because it is latched on this same edge.
    assign dec_in = (idx_nxt == 2'd0) ? live[0] : snap[idx_nxt];

    seg_decoder u_dec (
        .bcd (dec_in),
        .seg (dec_out)
    );

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = 1'b0;
        case (idx_nxt)
            2'd1:    blank = (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
            2'd2:    blank = (snap[3] == 4'd0) && (snap[2] == 4'd0);
            2'd3:    blank = (snap[3] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd3;
            snap  <= '0;
            flash <= '0;
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx <= idx_nxt;
                an  <= blank ? AN_OFF : an_for_slot(idx_nxt);
                seg <= blank ? SEG_BLANK : dec_out;
                dp  <= !((idx_nxt == 2'd0) && (flash_nxt != '0));
            end
            if (frame_start) begin
                snap  <= live;
                flash <= flash_nxt;
            end
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset, scan order, snapshot, flash, invalid BCD, reset abort.
module tb_score_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d1, d2, d3, d4;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    score_display #(.REFRESH_DIV(4), .FLASH_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .score_dig1 (d1),
        .score_dig2 (d2),
        .score_dig3 (d3),
        .score_dig4 (d4),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic slot_adv(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4;
        repeat (3) @(negedge clk);
        chk("rst_an",  7'(an), 7'b0001111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dp",  7'(dp), 7'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_tick_an", 7'(an), 7'b0001111);
        @(negedge clk);
        // F1: score 4321 differs from reset snapshot -> flash
        chk("f1s0_an",  7'(an), 7'b0001110);
        chk("f1s0_seg", seg, 7'b1111001);
        chk("f1s0_dp",  7'(dp), 7'd0);
        slot_adv(1);
        chk("f1s1_an",  7'(an), 7'b0001101);
        chk("f1s1_seg", seg, 7'b0100100);
        chk("f1s1_dp",  7'(dp), 7'd1);
        slot_adv(1);
        chk("f1s2_an",  7'(an), 7'b0001011);
        chk("f1s2_seg", seg, 7'b0110000);
        chk("f1s2_dp",  7'(dp), 7'd1);
        slot_adv(1);
        chk("f1s3_an",  7'(an), 7'b0000111);
        chk("f1s3_seg", seg, 7'b0011001);
        chk("f1s3_dp",  7'(dp), 7'd1);
        slot_adv(1);
        chk("f2s0_dp",  7'(dp), 7'd0);
        slot_adv(1);
        chk("f2s1_dp",  7'(dp), 7'd1);
        slot_adv(3);
        chk("f3s0_dp",  7'(dp), 7'd1);
        chk("f3s0_seg", seg, 7'b1111001);
        slot_adv(2);
        d1 = 4'd7;
        chk("f3s2_seg", seg, 7'b0110000);
        slot_adv(1);
        chk("f3s3_an",  7'(an), 7'b0000111);
        chk("f3s3_seg", seg, 7'b0011001);
        slot_adv(1);
        chk("f4s0_seg", seg, 7'b1111000);
        chk("f4s0_dp",  7'(dp), 7'd0);
        slot_adv(2);
        d1 = 4'd5;
        slot_adv(2);
        chk("f5s0_seg", seg, 7'b0010010);
        chk("f5s0_dp",  7'(dp), 7'd0);
        slot_adv(4);
        chk("f6s0_dp_reload", 7'(dp), 7'd0);
        slot_adv(4);
        chk("f7s0_dp",  7'(dp), 7'd1);
        slot_adv(1);
        d3 = 4'd12;
        slot_adv(3);
        chk("f8s0_dp",  7'(dp), 7'd0);
        slot_adv(2);
        chk("f8s2_an",   7'(an), 7'b0001011);
        chk("f8s2_dash", seg, 7'b0111111);
        d1 = 4'd9; d2 = 4'd9; d3 = 4'd9; d4 = 4'd9;
        slot_adv(2);
        chk("f9s0_seg", seg, 7'b0010000);
        chk("f9s0_dp",  7'(dp), 7'd0);
        slot_adv(8);
        chk("f11s0_dp", 7'(dp), 7'd1);
        d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; d4 = 4'd0;
        slot_adv(4);
        chk("wrap_seg", seg, 7'b1000000);
        chk("wrap_dp",  7'(dp), 7'd0);
        slot_adv(1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an",  7'(an), 7'b0001111);
        chk("midrst_seg", seg, 7'b1111111);
        chk("midrst_dp",  7'(dp), 7'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("postrst_an",  7'(an), 7'b0001110);
        chk("postrst_seg", seg, 7'b1000000);
        chk("postrst_dp",  7'(dp), 7'd1);
        d2 = 4'd5;
        slot_adv(4);
        chk("z50s0_an",  7'(an), 7'b0001110);
        slot_adv(1);
        chk("z50s1_an",  7'(an), 7'b0001101);
        chk("z50s1_seg", seg, 7'b0010010);
        slot_adv(1);
        chk("z50s2_an",  7'(an), 7'b0001011);
        slot_adv(1);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        chk("z50s3_blank", 7'(an), 7'b0001111);
        d2 = 4'd0;
        slot_adv(1);
        chk("z0s0_an",  7'(an), 7'b0001110);
        chk("z0s0_seg", seg, 7'b1000000);
        slot_adv(1);
        chk("z0s1_blank", 7'(an), 7'b0001111);
        slot_adv(1);
        chk("z0s2_blank", 7'(an), 7'b0001111);
        slot_adv(1);
        chk("z0s3_blank", 7'(an), 7'b0001111);
`else
        chk("z50s3_an",  7'(an), 7'b0000111);
        chk("z50s3_seg", seg, 7'b1000000);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
